// File: rtl/cve2_xif_copro_pkg.sv
// cve2_xif_copro_pkg
//   Shared definitions for the XIF reference coprocessor: the custom-0
//   opcode, the operation and FSM state encodings, the issue-channel decode
//   response, and small helper functions used by the datapath.
package cve2_xif_copro_pkg;

   localparam logic [6:0] CUSTOM0 = 7'b0001011;

   typedef enum logic [2:0] {
      OP_CADD   = 3'b000,
      OP_CPOPC  = 3'b001,
      OP_CMUL   = 3'b010,
      OP_CFENCE = 3'b011
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EXEC,
      RESULT
   } state_e;

   typedef struct packed {
      logic       accept;
      logic       writeback;
      logic [1:0] register_read;   // bit0 = rs1, bit1 = rs2
      op_e        op;
   } decode_t;

   // Combinational decode of an offloaded instruction.
   function automatic decode_t decode(input logic [31:0] instr);
      decode_t d;
      d.accept        = 1'b0;
      d.writeback     = 1'b0;
      d.register_read = 2'b00;
      d.op            = OP_CADD;
      if (instr[6:0] == CUSTOM0 && instr[31:25] == 7'b0000000) begin
         case (instr[14:12])
            3'b000: begin
               d.accept = 1'b1; d.writeback = 1'b1; d.register_read = 2'b11; d.op = OP_CADD;
            end
            3'b001: begin
               d.accept = 1'b1; d.writeback = 1'b1; d.register_read = 2'b01; d.op = OP_CPOPC;
            end
            3'b010: begin
               d.accept = 1'b1; d.writeback = 1'b1; d.register_read = 2'b11; d.op = OP_CMUL;
            end
            3'b011: begin
               d.accept = 1'b1; d.writeback = 1'b0; d.register_read = 2'b00; d.op = OP_CFENCE;
            end
            default: ;
         endcase
      end
      return d;
   endfunction

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/cve2_xif_copro_mul.sv
// cve2_xif_copro_mul
//   Iterative shift-add multiplier returning the low 32 bits of a*b.
//   A start pulse loads the operands; one multiplier bit is consumed per
//   cycle for 32 cycles. done is asserted during the 32nd step, with the
//   final product already presented combinationally on product.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start          load a/b and begin (ignored result of any run in progress)
//   a, b           operands, sampled on start
//   done           high for one cycle while the final step is in progress
//   product        low 32 bits of a*b, valid while done is high
module cve2_xif_copro_mul (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] product
);

   logic        busy;
   logic [4:0]  count;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] acc;
   logic [31:0] acc_next;

   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   // The last step's sum is forwarded so the caller can register it on
   // the same edge that retires the multiplier.
   assign done    = busy && (count == 5'd31);
   assign product = acc_next;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 5'd1;
         if (count == 5'd31) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cve2_xif_copro.sv
// cve2_xif_copro
//   Coprocessor endpoint of the CORE-V XIF interface implementing the
//   custom-0 ops CADD, CPOPC, CMUL and CFENCE, one instruction in flight.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   issue_*                   issue request and combinational decode response
//   commit_*                  commit/kill of the in-flight instruction
//   register_*                source operand transfer (rs1 = index 0)
//   result_*                  registered result, held until result_ready_i
//   result_ecs*/exc*/err/dbg  unused result fields, tied to 0
module cve2_xif_copro
   import cve2_xif_copro_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH     = 4,
   parameter int unsigned X_HARTID_WIDTH = 1,
   parameter int unsigned X_NUM_RS       = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          issue_valid_i,
   output logic                          issue_ready_o,
   input  logic [31:0]                   issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]         issue_id_i,
   input  logic [X_HARTID_WIDTH-1:0]     issue_hartid_i,
   output logic                          issue_accept_o,
   output logic                          issue_writeback_o,
   output logic [1:0]                    issue_register_read_o,
   output logic                          issue_ecswrite_o,
   input  logic                          commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]         commit_id_i,
   input  logic                          commit_kill_i,
   input  logic                          register_valid_i,
   output logic                          register_ready_o,
   input  logic [X_ID_WIDTH-1:0]         register_id_i,
   input  logic [X_NUM_RS-1:0][31:0]     register_rs_i,
   input  logic [X_NUM_RS-1:0]           register_rs_valid_i,
   output logic                          result_valid_o,
   input  logic                          result_ready_i,
   output logic [X_ID_WIDTH-1:0]         result_id_o,
   output logic [X_HARTID_WIDTH-1:0]     result_hartid_o,
   output logic [31:0]                   result_data_o,
   output logic [4:0]                    result_rd_o,
   output logic                          result_we_o,
   output logic [2:0]                    result_ecswe_o,
   output logic [5:0]                    result_ecsdata_o,
   output logic                          result_exc_o,
   output logic [5:0]                    result_exccode_o,
   output logic                          result_err_o,
   output logic                          result_dbg_o
);

   if (X_NUM_RS != 2) begin : g_num_rs_check
      $error("cve2_xif_copro: X_NUM_RS must be 2");
   end

   state_e                    state, state_next;
   decode_t                   dec;

   logic [X_ID_WIDTH-1:0]     id_reg;
   logic [X_HARTID_WIDTH-1:0] hartid_reg;
   logic [4:0]                rd_reg;
   op_e                       op_reg;
   logic [1:0]                rr_reg;
   logic                      op_flag;
   logic                      commit_flag;
   logic [31:0]               rs1_reg, rs2_reg;

   logic [X_ID_WIDTH-1:0]     res_id;
   logic [X_HARTID_WIDTH-1:0] res_hartid;
   logic [31:0]               res_data;
   logic [4:0]                res_rd;
   logic                      res_we;

   logic        issue_hs, reg_hs, reg_take;
   logic        commit_match, kill;
   logic        op_now, commit_now;
   logic        rs_ok;
   logic [31:0] rs1_eff, rs2_eff;
   logic [31:0] exec_data;
   logic        mul_start, mul_done;
   logic [31:0] mul_product;
   logic        unused_instr;

   assign unused_instr = ^issue_instr_i[24:15];

   assign dec = decode(issue_instr_i);

   // Every output is forced low while reset is held, including the
   // combinational ready/response signals.
   assign issue_ready_o         = !rst_i && (state == IDLE);
   assign issue_accept_o        = !rst_i && issue_valid_i && dec.accept;
   assign issue_writeback_o     = !rst_i && issue_valid_i && dec.writeback;
   assign issue_register_read_o = (!rst_i && issue_valid_i) ? dec.register_read : 2'b00;
   assign issue_ecswrite_o      = 1'b0;

   assign issue_hs = issue_valid_i && issue_ready_o;

   assign rs_ok = ((register_rs_valid_i & rr_reg) == rr_reg);

   // IDLE accepts any transfer so stale operands of a killed instruction
   // are drained rather than stalling the host.
   assign register_ready_o = !rst_i &&
                             ((state == IDLE) ||
                              (state == WAIT && !op_flag && register_id_i == id_reg && rs_ok));
   assign reg_hs = register_valid_i && register_ready_o;

   assign commit_match = (state == WAIT) && commit_valid_i && (commit_id_i == id_reg);
   assign kill         = commit_match && commit_kill_i;
   assign reg_take     = (state == WAIT) && reg_hs && !kill;

   // Same-cycle handshakes count immediately so EXEC follows the last one.
   assign op_now     = op_flag || reg_take;
   assign commit_now = commit_flag || (commit_match && !commit_kill_i);
   assign rs1_eff    = reg_take ? register_rs_i[0] : rs1_reg;
   assign rs2_eff    = reg_take ? register_rs_i[1] : rs2_reg;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (issue_hs && dec.accept) state_next = WAIT;
         WAIT: begin
            if (kill)                       state_next = IDLE;
            else if (op_now && commit_now)  state_next = EXEC;
         end
         EXEC:   if (op_reg != OP_CMUL || mul_done) state_next = RESULT;
         RESULT: if (result_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The multiplier is loaded on the WAIT->EXEC edge so its 32 steps
   // coincide exactly with the EXEC cycles.
   assign mul_start = (state == WAIT) && (state_next == EXEC) && (op_reg == OP_CMUL);

   cve2_xif_copro_mul u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (mul_start),
      .a       (rs1_eff),
      .b       (rs2_eff),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      exec_data = '0;
      case (op_reg)
         OP_CADD:   exec_data = rs1_reg + rs2_reg;
         OP_CPOPC:  exec_data = {26'd0, popcount(rs1_reg)};
         OP_CMUL:   exec_data = mul_product;
         OP_CFENCE: exec_data = '0;
         default:   exec_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         id_reg      <= '0;
         hartid_reg  <= '0;
         rd_reg      <= '0;
         op_reg      <= OP_CADD;
         rr_reg      <= '0;
         op_flag     <= 1'b0;
         commit_flag <= 1'b0;
         rs1_reg     <= '0;
         rs2_reg     <= '0;
         res_id      <= '0;
         res_hartid  <= '0;
         res_data    <= '0;
         res_rd      <= '0;
         res_we      <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (issue_hs && dec.accept) begin
                  id_reg      <= issue_id_i;
                  hartid_reg  <= issue_hartid_i;
                  rd_reg      <= issue_instr_i[11:7];
                  op_reg      <= dec.op;
                  rr_reg      <= dec.register_read;
                  op_flag     <= (dec.register_read == 2'b00);
                  commit_flag <= 1'b0;
               end
            end
            WAIT: begin
               if (kill) begin
                  op_flag     <= 1'b0;
                  commit_flag <= 1'b0;
                  rs1_reg     <= '0;
                  rs2_reg     <= '0;
               end else begin
                  if (reg_take) begin
                     rs1_reg <= register_rs_i[0];
                     rs2_reg <= register_rs_i[1];
                     op_flag <= 1'b1;
                  end
                  if (commit_match) begin
                     commit_flag <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (state_next == RESULT) begin
                  res_id     <= id_reg;
                  res_hartid <= hartid_reg;
                  res_rd     <= rd_reg;
                  res_we     <= (op_reg != OP_CFENCE);
                  res_data   <= exec_data;
               end
            end
            RESULT: begin
               if (result_ready_i) begin
                  res_id      <= '0;
                  res_hartid  <= '0;
                  res_rd      <= '0;
                  res_we      <= 1'b0;
                  res_data    <= '0;
                  op_flag     <= 1'b0;
                  commit_flag <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_valid_o   = (state == RESULT);
   assign result_id_o      = res_id;
   assign result_hartid_o  = res_hartid;
   assign result_data_o    = res_data;
   assign result_rd_o      = res_rd;
   assign result_we_o      = res_we;
   assign result_ecswe_o   = '0;
   assign result_ecsdata_o = '0;
   assign result_exc_o     = 1'b0;
   assign result_exccode_o = '0;
   assign result_err_o     = 1'b0;
   assign result_dbg_o     = 1'b0;

endmodule
